matmul_ctrl: RTL and testbench

//  Job sequencer for the 4x4 matmul core. Exposes ap_start/ap_done/ap_idle to the CPU via a simple register port.

---
 rtl/matmul_ctrl.sv | 147 ++++++++++++++
 tb/tb_matmul_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// Job sequencer for the 4x4 matmul core: CPU register port, start pulse,
// input/output stream gating with beat counting, tlast generation and interrupt.
module matmul_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int N_IN        = 32,
  parameter int N_OUT       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic                   cfg_re,
  input  logic [pADDR_WIDTH-1:0] cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  output logic                   cfg_rvalid,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   core_ap_start,
  output logic                   core_ss_tvalid,
  output logic [pDATA_WIDTH-1:0] core_ss_tdata,
  output logic                   core_ss_tlast,
  input  logic                   core_ss_tready,
  input  logic                   core_sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] core_sm_tdata,
  output logic                   core_sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   irq
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(12'h000);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CYC  = pADDR_WIDTH'(12'h004);
  localparam logic [pADDR_WIDTH-1:0] ADDR_IRQ  = pADDR_WIDTH'(12'h008);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q;
  logic [IW-1:0]          in_cnt_q;
  logic [OW-1:0]          out_cnt_q;
  logic [pDATA_WIDTH-1:0] cyc_cnt_q;
  logic                   irq_en_q;
  logic                   ap_done_q;
  logic                   ap_idle_q;
  logic                   err_q;
  logic                   core_ap_start_q;
  logic [pDATA_WIDTH-1:0] cfg_rdata_q;
  logic                   cfg_rvalid_q;
  logic [pDATA_WIDTH-1:0] rdata_d;

  logic run, in_en, out_en, in_fire, out_fire, in_last, out_last, done_evt;
  logic start_evt, rd_ctrl;
  logic unused_wdata;

  assign run      = (state_q == S_RUN);
  assign in_en    = run && (in_cnt_q < IW'(N_IN));
  assign out_en   = run && (out_cnt_q < OW'(N_OUT));
  assign in_last  = (in_cnt_q == IW'(N_IN - 1));
  assign out_last = (out_cnt_q == OW'(N_OUT - 1));

  assign core_ss_tvalid = in_en & ss_tvalid;
  assign ss_tready      = in_en & core_ss_tready;
  assign core_ss_tdata  = in_en ? ss_tdata : '0;
  assign core_ss_tlast  = in_last;

  assign sm_tvalid      = out_en & core_sm_tvalid;
  assign core_sm_tready = out_en & sm_tready;
  assign sm_tdata       = out_en ? core_sm_tdata : '0;
  assign sm_tlast       = sm_tvalid & out_last;

  assign in_fire   = ss_tvalid & ss_tready;
  assign out_fire  = sm_tvalid & sm_tready;
  assign done_evt  = out_fire & out_last;
  assign start_evt = !run && cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[0];
  assign rd_ctrl   = cfg_re && (cfg_addr == ADDR_CTRL);
  assign unused_wdata = ^cfg_wdata[pDATA_WIDTH-1:1];

  assign core_ap_start = core_ap_start_q;
  assign cfg_rdata     = cfg_rdata_q;
  assign cfg_rvalid    = cfg_rvalid_q;
  assign irq           = ap_done_q & irq_en_q;

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = '0;
    if (cfg_addr == ADDR_CTRL) rdata_d[3:0] = {err_q, ap_idle_q, ap_done_q, run};
    else if (cfg_addr == ADDR_CYC) rdata_d = cyc_cnt_q;
    else if (cfg_addr == ADDR_IRQ) rdata_d[0] = irq_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
      cyc_cnt_q       <= '0;
      irq_en_q        <= 1'b0;
      ap_done_q       <= 1'b0;
      ap_idle_q       <= 1'b1;
      err_q           <= 1'b0;
      core_ap_start_q <= 1'b0;
      cfg_rdata_q     <= '0;
      cfg_rvalid_q    <= 1'b0;
    end else begin
      core_ap_start_q <= start_evt;
      cfg_rvalid_q    <= cfg_re;
      if (cfg_re) cfg_rdata_q <= rdata_d;
      if (cfg_we && (cfg_addr == ADDR_IRQ)) irq_en_q <= cfg_wdata[0];
      // Clear-on-read comes first so a coinciding done-set overrides it.
      if (rd_ctrl) ap_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            state_q   <= S_RUN;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            cyc_cnt_q <= '0;
            err_q     <= 1'b0;
            ap_done_q <= 1'b0;
            ap_idle_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 1'b1;
          if (in_fire) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (ss_tlast != in_last) err_q <= 1'b1;
          end
          if (out_fire) out_cnt_q <= out_cnt_q + 1'b1;
          if (done_evt) begin
            state_q   <= S_IDLE;
            ap_done_q <= 1'b1;
            ap_idle_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: the bench plays both DMA and core, checks
// gating, counts, status bits, interrupt and reset behaviour against hand values.
module tb_matmul_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_re;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_rvalid;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        core_ap_start;
  logic        core_ss_tvalid, core_ss_tlast, core_ss_tready;
  logic [31:0] core_ss_tdata;
  logic        core_sm_tvalid, core_sm_tready;
  logic [31:0] core_sm_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  matmul_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .core_ap_start(core_ap_start),
    .core_ss_tvalid(core_ss_tvalid), .core_ss_tdata(core_ss_tdata),
    .core_ss_tlast(core_ss_tlast), .core_ss_tready(core_ss_tready),
    .core_sm_tvalid(core_sm_tvalid), .core_sm_tdata(core_sm_tdata),
    .core_sm_tready(core_sm_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_re = 0; cfg_addr = '0; cfg_wdata = '0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; core_ss_tready = 0;
    core_sm_tvalid = 0; core_sm_tdata = '0; sm_tready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, cfg_rdata, 0);
    check({tag, "_rvalid"}, {31'b0, cfg_rvalid}, 0);
    check({tag, "_start"}, {31'b0, core_ap_start}, 0);
    check({tag, "_ctl"}, {26'b0, ss_tready, core_ss_tvalid, core_ss_tlast,
                          core_sm_tready, sm_tvalid, sm_tlast}, 0);
    check({tag, "_irq"}, {31'b0, irq}, 0);
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    cfg_re = 1; cfg_addr = a;
    @(negedge clk);
    cfg_re = 0;
    check({tag, "_rvalid"}, {31'b0, cfg_rvalid}, 1);
    check(tag, cfg_rdata, exp);
  endtask

  task automatic start_job(input string tag);
    cfg_write(12'h000, 32'h1);
    check({tag, "_start_hi"}, {31'b0, core_ap_start}, 1);
    @(negedge clk);
    check({tag, "_start_lo"}, {31'b0, core_ap_start}, 0);
  endtask

  task automatic stream_in(input int first, input int n, input int tlast_at);
    for (int i = 0; i < n; i++) begin
      ss_tvalid = 1; ss_tdata = 32'hA000_0000 + (first + i);
      ss_tlast = ((first + i) == tlast_at); core_ss_tready = 1;
      #1;
      check("in_hs", {30'b0, ss_tready, core_ss_tvalid}, 32'h3);
      check("in_data", core_ss_tdata, 32'hA000_0000 + (first + i));
      check("in_last", {31'b0, core_ss_tlast}, {31'b0, ((first + i) == 31)});
      @(negedge clk);
    end
    ss_tvalid = 0; ss_tlast = 0;
  endtask

  task automatic stream_out(input int first, input int n, input int stall_at);
    for (int j = first; j < first + n; j++) begin
      core_sm_tvalid = 1; core_sm_tdata = 32'hC000_0000 + j;
      if (j == stall_at) begin
        for (int s = 0; s < 10; s++) begin
          sm_tready = 0;
          #1;
          check("stall_rdy", {31'b0, core_sm_tready}, 0);
          check("stall_vld_last", {30'b0, sm_tvalid, sm_tlast}, 32'h2);
          @(negedge clk);
        end
      end
      sm_tready = 1;
      #1;
      check("out_hs", {30'b0, sm_tvalid, core_sm_tready}, 32'h3);
      check("out_data", sm_tdata, 32'hC000_0000 + j);
      check("out_last", {31'b0, sm_tlast}, {31'b0, (j == 15)});
      @(negedge clk);
    end
    if (first + n == 16) begin
      #1;
      check("out_closed", {31'b0, sm_tvalid}, 0);
    end
    core_sm_tvalid = 0; sm_tready = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);
    read_check("stat_reset", 12'h000, 32'h4);
    read_check("unmapped", 12'h010, 32'h0);

    // Job 1: clean job, no stalls; RUN spans 50 edges.
    start_job("job1");
    stream_in(0, 32, 31);
    ss_tvalid = 1; #1;
    check("beat33", {30'b0, ss_tready, core_ss_tvalid}, 0);
    @(negedge clk);
    ss_tvalid = 0;
    stream_out(0, 16, -1);
    check("irq_disabled", {31'b0, irq}, 0);
    read_check("stat_done", 12'h000, 32'h6);
    read_check("stat_cleared", 12'h000, 32'h4);
    read_check("cyc_job1", 12'h004, 32'd50);

    // Simultaneous write and read of irq_en.
    cfg_we = 1; cfg_re = 1; cfg_addr = 12'h008; cfg_wdata = 32'h1;
    @(negedge clk);
    cfg_we = 0; cfg_re = 0;
    check("wr_rd_prewrite", cfg_rdata, 0);
    read_check("irq_en_set", 12'h008, 32'h1);

    // Job 2: early tlast on beat 5, output stall, interrupt.
    start_job("job2");
    stream_in(0, 32, 4);
    stream_out(0, 16, 5);
    check("irq_raised", {31'b0, irq}, 1);
    read_check("stat_err", 12'h000, 32'hE);
    check("irq_cleared", {31'b0, irq}, 0);

    // Job 3: done edge coincides with a status read.
    start_job("job3");
    stream_in(0, 32, 31);
    stream_out(0, 15, -1);
    core_sm_tvalid = 1; core_sm_tdata = 32'hC000_000F; sm_tready = 1;
    cfg_re = 1; cfg_addr = 12'h000;
    #1;
    check("j3_last", {31'b0, sm_tlast}, 1);
    @(negedge clk);
    cfg_re = 0; core_sm_tvalid = 0; sm_tready = 0;
    check("race_rvalid", {31'b0, cfg_rvalid}, 1);
    check("race_rdata", cfg_rdata, 32'h1);
    check("race_irq", {31'b0, irq}, 1);
    read_check("race_stat", 12'h000, 32'h6);
    check("race_irq_clr", {31'b0, irq}, 0);

    // Job 4: start during RUN is ignored, then reset mid-input.
    start_job("job4");
    stream_in(0, 10, -1);
    read_check("cyc_before", 12'h004, 32'd11);
    cfg_write(12'h000, 32'h1);
    check("restart_nopulse", {31'b0, core_ap_start}, 0);
    read_check("cyc_after", 12'h004, 32'd13);
    ss_tvalid = 1; core_ss_tready = 1; core_sm_tvalid = 1; sm_tready = 1;
    #1;
    check("pre_reset_active", {31'b0, ss_tready}, 1);
    rst_n = 0;
    #1;
    check_all_zero("midreset");
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    read_check("stat_post_reset", 12'h000, 32'h4);
    read_check("cyc_post_reset", 12'h004, 32'h0);
    read_check("irq_en_post_reset", 12'h008, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
